// File: rtl/mod3_sched_pkg.sv
// Shared types, symbol encodings and residue arithmetic for the mod-3 burst scheduler.
package mod3_sched_pkg;

    localparam int unsigned SYM_W = 2;
    localparam int unsigned RES_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        RESULT = 2'd2
    } state_e;

    localparam logic [SYM_W-1:0] SYM_ZERO = 2'b00;
    localparam logic [SYM_W-1:0] SYM_TWO  = 2'b11;

    typedef struct packed {
        logic [RES_W-1:0] residue;
        logic             q;
        logic             err;
    } res_info_t;

    // One residue step; residue is always 0..2 so the sum never exceeds 4.
    function automatic logic [RES_W-1:0] mod3_step(input logic [RES_W-1:0] residue,
                                                   input logic [SYM_W-1:0] sym);
        logic [2:0] inc;
        logic [2:0] sum;
        inc = (sym == SYM_ZERO) ? 3'd0 : (sym == SYM_TWO) ? 3'd2 : 3'd1;
        sum = {1'b0, residue} + inc;
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mod3_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping.
module mod3_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  pick,
    output logic            any
);

    always_comb begin
        logic [IDW-1:0] idx;
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = IDW'((32'(rr_ptr) + off) % NREQ);
            if (!any && req_valid[idx]) begin
                any  = 1'b1;
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mod3_burst_scheduler.sv
// Round-robin scheduler sharing one mod-3 residue engine among NREQ burst requesters.
// Define MOD3_SCHED_WATCHDOG_EN to end stalled bursts after TIMEOUT idle cycles.
module mod3_burst_scheduler
    import mod3_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [SYM_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [RES_W-1:0]      res_residue,
    output logic                  res_q,
    output logic                  res_err,
    output logic                  busy
);

    if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || TIMEOUT == 0) begin : g_param_check
        $error("mod3_burst_scheduler: illegal parameter combination");
    end

    logic [SYM_W-1:0] sym_arr [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_sym
        assign sym_arr[g] = req_data[SYM_W*g +: SYM_W];
    end

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [RES_W-1:0] residue_q, residue_d;
    logic [NREQ-1:0]  req_ready_q, req_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    res_info_t        res_info_q, res_info_d;
    logic             busy_q, busy_d;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

`ifdef MOD3_SCHED_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;
`endif

    mod3_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .pick      (pick_idx),
        .any       (pick_any)
    );

    // Next state, context update and registered-output targets.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        residue_d  = residue_q;
        res_id_d   = res_id_q;
        res_info_d = res_info_q;
`ifdef MOD3_SCHED_WATCHDOG_EN
        wd_d       = wd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d     = pick_idx;
                    residue_d = '0;
                    state_d   = BURST;
`ifdef MOD3_SCHED_WATCHDOG_EN
                    wd_d      = '0;
`endif
                end
            end
            BURST: begin
                if (req_valid[gnt_q]) begin
                    residue_d = mod3_step(residue_q, sym_arr[gnt_q]);
`ifdef MOD3_SCHED_WATCHDOG_EN
                    wd_d      = '0;
`endif
                    if (req_last[gnt_q]) begin
                        state_d    = RESULT;
                        res_id_d   = gnt_q;
                        res_info_d = '{residue: residue_d, q: (residue_d == '0), err: 1'b0};
                    end
                end
`ifdef MOD3_SCHED_WATCHDOG_EN
                else if (32'(wd_q) + 32'd1 >= TIMEOUT) begin
                    state_d    = RESULT;
                    res_id_d   = gnt_q;
                    res_info_d = '{residue: residue_q, q: (residue_q == '0), err: 1'b1};
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
`endif
            end
            RESULT: begin
                if (res_ready) begin
                    rr_ptr_d   = IDW'((32'(gnt_q) + 32'd1) % NREQ);
                    state_d    = IDLE;
                    res_id_d   = '0;
                    res_info_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == BURST) ? (NREQ'(1) << gnt_d) : '0;
        res_valid_d = (state_d == RESULT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            residue_q   <= '0;
            req_ready_q <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_info_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            residue_q   <= residue_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_info_q  <= res_info_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MOD3_SCHED_WATCHDOG_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign req_ready   = req_ready_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_residue = res_info_q.residue;
    assign res_q       = res_info_q.q;
    assign res_err     = res_info_q.err;
    assign busy        = busy_q;

endmodule
